// File: rtl/serializer_gearbox.sv
// Multi-lane gearbox: DATA_W-bit words in, OUT_W-bit slices out LSB-first, shared handshake.
// Optional saturating underrun counter enabled by SERIALIZER_UNDERRUN_CNT_EN.
module serializer_gearbox #(
    parameter int                CHANNELS  = 3,
    parameter int                DATA_W    = 10,
    parameter int                OUT_W     = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD = '1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [CHANNELS*DATA_W-1:0] i_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    output logic [CHANNELS*OUT_W-1:0]  o_data,
    output logic                       o_word_start,
    output logic                       o_underrun
`ifdef SERIALIZER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                o_underrun_count
`endif
);
    localparam int RATIO = DATA_W / OUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if (DATA_W % OUT_W != 0) begin : g_bad_ratio
        $error("serializer_gearbox: DATA_W must be a multiple of OUT_W");
    end

    typedef enum logic {ST_START, ST_RUN} state_t;

    state_t                           state_q, state_nxt;
    logic [CNT_W-1:0]                 slice_cnt;
    logic                             hold_full;
    logic                             boundary;
    logic                             accept;
    logic                             underrun_nxt;
    logic [CHANNELS-1:0][DATA_W-1:0]  data_lanes;
    logic [CHANNELS-1:0][OUT_W-1:0]   out_lanes;

    assign boundary   = (slice_cnt == CNT_W'(RATIO - 1));
    // Holding register can drain and refill on the same boundary edge.
    assign o_ready    = !i_rst && (!hold_full || boundary);
    assign accept     = i_valid && o_ready;
    assign data_lanes = i_data;
    assign o_data     = out_lanes;

    always_comb begin
        state_nxt    = state_q;
        underrun_nxt = 1'b0;
        case (state_q)
            ST_START: if (boundary && hold_full) state_nxt = ST_RUN;
            ST_RUN:   if (boundary && !hold_full) underrun_nxt = 1'b1;
            default:  state_nxt = ST_START;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_START;
            slice_cnt    <= '0;
            hold_full    <= 1'b0;
            o_word_start <= 1'b0;
            o_underrun   <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            slice_cnt    <= boundary ? '0 : slice_cnt + CNT_W'(1);
            o_word_start <= boundary;
            o_underrun   <= underrun_nxt;
            if (accept)
                hold_full <= 1'b1;
            else if (boundary)
                hold_full <= 1'b0;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [DATA_W-1:0] hold_q;
        logic [DATA_W-1:0] shift_q;

        // A word accepted on a boundary with an empty hold is not loaded until the next boundary.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                hold_q  <= '0;
                shift_q <= IDLE_WORD;
            end else begin
                if (accept)
                    hold_q <= data_lanes[c];
                if (boundary)
                    shift_q <= hold_full ? hold_q : IDLE_WORD;
                else
                    shift_q <= shift_q >> OUT_W;
            end
        end

        assign out_lanes[c] = shift_q[OUT_W-1:0];
    end

`ifdef SERIALIZER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            underrun_cnt_q <= '0;
        else if (o_underrun && underrun_cnt_q != 16'hFFFF)
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end

    assign o_underrun_count = underrun_cnt_q;
`endif

endmodule

// File: doc/serializer_gearbox.md
# serializer_gearbox

Parametrised multi-channel fabric serializer (gearbox). It accepts DATA_W-bit parallel words per channel over a valid/ready handshake and emits them LSB-first as OUT_W-bit slices, one slice per clock. A one-entry holding register double-buffers input so back-to-back words stream without gaps, and an idle word is inserted on starvation. It sits between the TMDS encoders and the narrow-width output primitives, so the whole encoder-to-pin path runs in one clock domain.

## Interface
- DATA_W, 10, parallel word width per channel
- OUT_W, 2, output slice width per channel; DATA_W % OUT_W must be 0, otherwise elaboration fails with $error
- CHANNELS, 3, number of lanes; all lanes share one handshake and one slice counter
- IDLE_WORD, all-ones (DATA_W bits), word shifted out after reset and on underrun
- i_clk  in  1  the single clock
- i_rst  in  1  reset, synchronous, active-high
- i_data  in  CHANNELS*DATA_W  parallel words; lane c occupies [c*DATA_W +: DATA_W]
- i_valid  in  1  i_data is valid
- o_ready  out  1  the block accepts i_data this cycle
- o_data  out  CHANNELS*OUT_W  current slice; lane c occupies [c*OUT_W +: OUT_W]
- o_word_start  out  1  o_data holds slice 0 of a word
- o_underrun  out  1  one-cycle pulse when IDLE_WORD was substituted for missing data

## Operation
- RATIO = DATA_W/OUT_W. slice_cnt counts 0..RATIO-1 and wraps. A "boundary edge" is the rising edge that ends a cycle with slice_cnt==RATIO-1.
- Holding register plus flag hold_full:
  - Accept occurs when i_valid && o_ready.
  - o_ready = !i_rst && (!hold_full || boundary), with boundary = (slice_cnt==RATIO-1). A drain and a refill may happen on the same edge.
- Shift register, one per lane. It is the output register: o_data = shift[OUT_W-1:0].
  - Non-boundary edge: shift >>= OUT_W.
  - Boundary edge: shift loads the holding register if hold_full, else IDLE_WORD.
- A word accepted on a boundary edge while hold_full==0 is not loaded on that edge; it waits for the next boundary.
- State machine:
  - START: the state after reset. IDLE_WORD is substituted without flagging an underrun. Moves to RUN on the first boundary edge that loads real data.
  - RUN: a boundary edge with hold_full==0 loads IDLE_WORD and sets o_underrun=1 for the next cycle. The block stays in RUN.
- o_word_start is 1 in the cycle after every boundary edge, including edges that load IDLE_WORD.
- Reset, including mid-word: slice_cnt=0, hold_full=0, state=START, shift=IDLE_WORD. Any held or partially shifted word is dropped.

## Timing
- Reset values: o_data=IDLE_WORD[OUT_W-1:0] per lane, o_ready=0 while i_rst=1, o_word_start=0, o_underrun=0. Underrun count (if compiled in) = 0.
- Cycles are numbered from 0, the first cycle with i_rst=0. o_ready=1 in cycle 0.
- First boundary edge is the end of cycle RATIO-1.
- Word accepted in cycle t appears at the first boundary edge after t, starting slice 0.
- Latency, accept to slice 0 on o_data: 2..RATIO+1 cycles.
- Sustained throughput is one word per RATIO cycles with no gaps while i_valid stays high.
- RATIO==1: every edge is a boundary. o_ready is 1 whenever not in reset, and latency is 2 cycles.

## Configuration
- SERIALIZER_UNDERRUN_CNT_EN defined:
  - Adds output o_underrun_count (16 bits).
  - Increments on each o_underrun pulse and saturates at 16'hFFFF.
  - Cleared only by i_rst.
- Not defined: the port and the counter are absent. o_underrun is still present.

## Test plan
- Defaults, CHANNELS=1, RATIO=5. Present 10'h335 in cycle 0. Boundary edge ends cycle 4, so the word shows cycles 5..9: o_data = 01,01,11,00,11, o_word_start=1 in cycle 5 only, o_underrun=0.
- Stream 8 words with i_valid held high. Required: o_data is continuous with no IDLE_WORD between words, o_ready=1 at least once per 5 cycles, and o_word_start asserts every 5th cycle.
- Starve after one word in RUN. Required: the next boundary loads 10'h3FF (slices 11×5), o_underrun=1 for exactly 1 cycle together with o_word_start, and o_underrun_count increments by 1.
- Hold i_valid low after reset for 20 cycles. Required: o_data=11 throughout and o_underrun never asserts (START state).
- Assert i_rst at slice 2 of a word while the holding register is full. Required: next cycle o_data=11 and o_ready=0; after release, both words are lost and no underrun is flagged.
- CHANNELS=3, OUT_W=10 (RATIO=1). Accept lanes {3FF,155,2AA} in cycle 0; they appear in cycle 2 with o_word_start=1 every cycle.
